// File: rtl/gmm_pkg.sv
// Shared types and constants for the GMM complex datapath blocks.
package gmm_pkg;

   localparam int unsigned GMM_SIZEIN   = 16;
   localparam int unsigned GMM_TAGW     = 4;
   localparam int unsigned GMM_CNTW     = 16;
   localparam int unsigned CSUB_LATENCY = 2;

   // Full-precision complex result of an add/subtract on GMM_SIZEIN-bit operands
   typedef struct packed {
      logic signed [GMM_SIZEIN:0] re;
      logic signed [GMM_SIZEIN:0] im;
   } cplx_t;

endpackage

// File: rtl/csub_pipe_ctl.sv
// Valid/ready control for a two-register-stage streaming pipe (S1 -> S2).
module csub_pipe_ctl (
   input  logic clk,
   input  logic rst,
   input  logic i_ce,
   input  logic i_in_valid,
   input  logic i_out_ready,
   output logic o_in_ready_c,
   output logic o_ld1_c,
   output logic o_ld2_c,
   output logic o_s2_valid
);

   logic r_s1_valid;
   logic r_s2_valid;
   logic w_ld1;
   logic w_ld2;
   logic w_in_ready;

   // S2 refills when empty or draining; S1 refills when empty or moving into S2
   always_comb begin
      w_ld2      = i_ce && r_s1_valid && (!r_s2_valid || i_out_ready);
      w_ld1      = i_ce && (!r_s1_valid || w_ld2);
      w_in_ready = rst && i_ce && (!r_s1_valid || !r_s2_valid || i_out_ready);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_s1_valid <= 1'b0;
         r_s2_valid <= 1'b0;
      end else begin
         if (w_ld1) begin
            r_s1_valid <= i_in_valid && w_in_ready;
         end
         if (w_ld2) begin
            r_s2_valid <= 1'b1;
         end else if (i_ce && i_out_ready && r_s2_valid) begin
            r_s2_valid <= 1'b0;
         end
      end
   end

   assign o_in_ready_c = w_in_ready;
   assign o_ld1_c      = w_ld1;
   assign o_ld2_c      = w_ld2;
   assign o_s2_valid   = r_s2_valid;

endmodule

// File: rtl/csub_stream.sv
// Streaming complex subtractor s = a - b with valid/ready flow control,
// sideband tag/last pass-through, output beat counter and end-of-vector pulse.
module csub_stream
   import gmm_pkg::*;
#(
   parameter int unsigned SIZEIN = GMM_SIZEIN,
   parameter int unsigned TAGW   = GMM_TAGW,
   parameter int unsigned CNTW   = GMM_CNTW
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     ce,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic signed [SIZEIN-1:0] ar,
   input  logic signed [SIZEIN-1:0] ai,
   input  logic signed [SIZEIN-1:0] br,
   input  logic signed [SIZEIN-1:0] bi,
   input  logic [TAGW-1:0]          in_tag,
   input  logic                     in_last,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic signed [SIZEIN:0]   sr,
   output logic signed [SIZEIN:0]   si,
   output logic [TAGW-1:0]          out_tag,
   output logic                     out_last,
   output logic [CNTW-1:0]          beat_cnt,
   output logic                     vec_done
);

   localparam int unsigned SW = SIZEIN + 1;

   logic w_ld1;
   logic w_ld2;
   logic w_in_ready;
   logic w_s2_valid;
   logic w_out_hs;
   logic signed [SW-1:0] w_dr;
   logic signed [SW-1:0] w_di;

   logic signed [SIZEIN-1:0] r_ar;
   logic signed [SIZEIN-1:0] r_ai;
   logic signed [SIZEIN-1:0] r_br;
   logic signed [SIZEIN-1:0] r_bi;
   logic [TAGW-1:0]          r_s1_tag;
   logic                     r_s1_last;

   (* use_dsp = "yes" *) logic signed [SW-1:0] r_sr;
   (* use_dsp = "yes" *) logic signed [SW-1:0] r_si;
   logic [TAGW-1:0]          r_s2_tag;
   logic                     r_s2_last;
   logic [CNTW-1:0]          r_beat_cnt;
   logic                     r_vec_done;

   csub_pipe_ctl u_ctl (
      .clk          (clk),
      .rst          (rst),
      .i_ce         (ce),
      .i_in_valid   (in_valid),
      .i_out_ready  (out_ready),
      .o_in_ready_c (w_in_ready),
      .o_ld1_c      (w_ld1),
      .o_ld2_c      (w_ld2),
      .o_s2_valid   (w_s2_valid)
   );

   // Sign-extend before subtracting so the result is exact for every input pair
   always_comb begin
      w_dr     = SW'(r_ar) - SW'(r_br);
      w_di     = SW'(r_ai) - SW'(r_bi);
      w_out_hs = ce && w_s2_valid && out_ready;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_ar      <= '0;
         r_ai      <= '0;
         r_br      <= '0;
         r_bi      <= '0;
         r_s1_tag  <= '0;
         r_s1_last <= 1'b0;
      end else if (w_ld1) begin
         r_ar      <= ar;
         r_ai      <= ai;
         r_br      <= br;
         r_bi      <= bi;
         r_s1_tag  <= in_tag;
         r_s1_last <= in_last;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_sr      <= '0;
         r_si      <= '0;
         r_s2_tag  <= '0;
         r_s2_last <= 1'b0;
      end else if (w_ld2) begin
         r_sr      <= w_dr;
         r_si      <= w_di;
         r_s2_tag  <= r_s1_tag;
         r_s2_last <= r_s1_last;
      end
   end

   // Output handshake counter (wraps) and end-of-vector pulse
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_beat_cnt <= '0;
         r_vec_done <= 1'b0;
      end else begin
         if (w_out_hs) begin
            r_beat_cnt <= r_beat_cnt + CNTW'(1);
         end
         r_vec_done <= w_out_hs && r_s2_last;
      end
   end

   assign in_ready  = w_in_ready;
   assign out_valid = w_s2_valid;
   assign sr        = r_sr;
   assign si        = r_si;
   assign out_tag   = r_s2_tag;
   assign out_last  = r_s2_last;
   assign beat_cnt  = r_beat_cnt;
   assign vec_done  = r_vec_done;

endmodule

// File: tb/tb_csub_stream.sv
// Bench for csub_stream: directed scenarios plus a randomized run against a queue-based model.
module tb_csub_stream;
   import gmm_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic ce = 1'b0;
   logic in_valid = 1'b0;
   logic out_ready = 1'b0;
   logic in_last = 1'b0;
   logic signed [15:0] ar = '0, ai = '0, br = '0, bi = '0;
   logic [3:0] in_tag = '0;

   logic in_ready, out_valid, out_last, vec_done;
   logic signed [16:0] sr, si;
   logic [3:0] out_tag;
   logic [15:0] beat_cnt;

   logic in_ready2, out_valid2, out_last2, vec_done2;
   logic signed [16:0] sr2, si2;
   logic [3:0] out_tag2;
   logic [1:0] beat_cnt2;

   int n_tests = 0;
   int n_fail = 0;

   csub_stream #(.SIZEIN(16), .TAGW(4), .CNTW(16)) dut (
      .clk(clk), .rst(rst), .ce(ce), .in_valid(in_valid), .in_ready(in_ready),
      .ar(ar), .ai(ai), .br(br), .bi(bi), .in_tag(in_tag), .in_last(in_last),
      .out_valid(out_valid), .out_ready(out_ready), .sr(sr), .si(si),
      .out_tag(out_tag), .out_last(out_last), .beat_cnt(beat_cnt), .vec_done(vec_done)
   );

   csub_stream #(.SIZEIN(16), .TAGW(4), .CNTW(2)) dut_w2 (
      .clk(clk), .rst(rst), .ce(ce), .in_valid(in_valid), .in_ready(in_ready2),
      .ar(ar), .ai(ai), .br(br), .bi(bi), .in_tag(in_tag), .in_last(in_last),
      .out_valid(out_valid2), .out_ready(out_ready), .sr(sr2), .si(si2),
      .out_tag(out_tag2), .out_last(out_last2), .beat_cnt(beat_cnt2), .vec_done(vec_done2)
   );

   always #5 clk = ~clk;

   // Reference model: FIFO of accepted beats, each stamped with the enabled-edge count at acceptance
   typedef struct {
      int     re;
      int     im;
      int     tag;
      bit     last;
      longint t;
   } beat_t;

   beat_t  q[$];
   longint ce_edges = 0;
   longint exp_cnt = 0;
   bit     exp_vd = 0;
   bit     have_prev = 0;
   logic signed [16:0] prev_sr, prev_si;
   logic [3:0] prev_tag;
   logic prev_last;

   always @(negedge clk) begin
      bit exp_ir, exp_ov, hs_out, nvd;
      beat_t b;
      if (!rst) begin
         q.delete();
         exp_cnt   = 0;
         exp_vd    = 0;
         have_prev = 0;
      end else begin
         exp_ir = ce && (q.size() < 2 || out_ready);
         exp_ov = 0;
         if (q.size() > 0) exp_ov = (ce_edges - q[0].t) >= longint'(CSUB_LATENCY);
         n_tests++;
         if (in_ready !== exp_ir) begin
            n_fail++; $display("FAIL mon_in_ready t=%0t got %b expected %b", $time, in_ready, exp_ir);
         end
         n_tests++;
         if (out_valid !== exp_ov) begin
            n_fail++; $display("FAIL mon_out_valid t=%0t got %b expected %b", $time, out_valid, exp_ov);
         end
         if (exp_ov) begin
            b = q[0];
            n_tests++;
            if (int'(sr) !== b.re || int'(si) !== b.im || int'(out_tag) !== b.tag || out_last !== b.last) begin
               n_fail++;
               $display("FAIL mon_data t=%0t got sr=%0d si=%0d tag=%0d last=%b expected sr=%0d si=%0d tag=%0d last=%b",
                        $time, sr, si, out_tag, out_last, b.re, b.im, b.tag, b.last);
            end
            if (have_prev) begin
               n_tests++;
               if (sr !== prev_sr || si !== prev_si || out_tag !== prev_tag || out_last !== prev_last) begin
                  n_fail++;
                  $display("FAIL mon_stall_hold t=%0t got sr=%0d si=%0d expected sr=%0d si=%0d",
                           $time, sr, si, prev_sr, prev_si);
               end
            end
         end
         n_tests++;
         if (beat_cnt !== 16'(exp_cnt) || beat_cnt2 !== 2'(exp_cnt)) begin
            n_fail++;
            $display("FAIL mon_beat_cnt t=%0t got %0d/%0d expected %0d/%0d",
                     $time, beat_cnt, beat_cnt2, 16'(exp_cnt), 2'(exp_cnt));
         end
         n_tests++;
         if (vec_done !== exp_vd) begin
            n_fail++; $display("FAIL mon_vec_done t=%0t got %b expected %b", $time, vec_done, exp_vd);
         end
         hs_out    = exp_ov && out_ready && ce;
         have_prev = exp_ov && !hs_out;
         prev_sr   = sr;
         prev_si   = si;
         prev_tag  = out_tag;
         prev_last = out_last;
         nvd = 0;
         if (hs_out) begin
            nvd = q[0].last;
            void'(q.pop_front());
            exp_cnt++;
         end
         if (in_valid && exp_ir) begin
            b.re = int'(ar) - int'(br);
            b.im = int'(ai) - int'(bi);
            b.tag = int'(in_tag);
            b.last = in_last;
            b.t = ce_edges;
            q.push_back(b);
         end
         if (ce) ce_edges++;
         exp_vd = nvd;
      end
   end

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send(input logic signed [15:0] a_r, a_i, b_r, b_i,
                       input logic [3:0] tag, input logic last, output bit ok);
      ar = a_r; ai = a_i; br = b_r; bi = b_i; in_tag = tag; in_last = last;
      in_valid = 1'b1;
      ok = 0;
      for (int k = 0; k < 50 && !ok; k++) begin
         @(negedge clk);
         ok = in_ready;
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
   endtask

   task automatic pulse_reset();
      @(posedge clk);
      #2 rst = 1'b0;
      @(posedge clk);
      #1 rst = 1'b1;
   endtask

   task automatic test_reset();
      bit ok;
      #1;
      n_tests++;
      if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
         n_fail++; $display("FAIL reset_initial got in_ready=%b out_valid=%b expected 0 0", in_ready, out_valid);
      end
      ce = 1'b1;
      cyc(2);
      n_tests++;
      if (in_ready !== 1'b0) begin
         n_fail++; $display("FAIL reset_in_ready_held got %b expected 0", in_ready);
      end
      rst = 1'b1;
      out_ready = 1'b1;
      cyc(1);
      send(16'sd9, 16'sd9, 16'sd1, 16'sd2, 4'd3, 1'b0, ok);
      cyc(3);
      out_ready = 1'b0;
      send(16'sd5, 16'sd6, 16'sd1, 16'sd1, 4'd7, 1'b1, ok);
      cyc(3);
      n_tests++;
      if (out_valid !== 1'b1 || sr !== 17'sd4 || beat_cnt !== 16'd1) begin
         n_fail++; $display("FAIL reset_prefill got ov=%b sr=%0d cnt=%0d expected 1 4 1", out_valid, sr, beat_cnt);
      end
      @(posedge clk);
      #2 rst = 1'b0;
      #1;
      n_tests++;
      if (out_valid !== 1'b0 || sr !== 17'sd0 || si !== 17'sd0 || beat_cnt !== 16'd0 ||
          out_tag !== 4'd0 || out_last !== 1'b0 || in_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_async got ov=%b sr=%0d si=%0d cnt=%0d tag=%0d last=%b rdy=%b expected all 0",
                  out_valid, sr, si, beat_cnt, out_tag, out_last, in_ready);
      end
      @(posedge clk);
      #1 rst = 1'b1;
      out_ready = 1'b1;
      cyc(2);
   endtask

   task automatic test_directed(input logic signed [15:0] a_r, a_i, b_r, b_i,
                                input int e_r, e_i, input string name);
      bit ok;
      out_ready = 1'b1;
      send(a_r, a_i, b_r, b_i, 4'd1, 1'b0, ok);
      n_tests++;
      if (!ok) begin
         n_fail++; $display("FAIL %s_accept timed out", name);
      end
      n_tests++;
      if (out_valid !== 1'b0) begin
         n_fail++; $display("FAIL %s_early got out_valid=%b expected 0", name, out_valid);
      end
      cyc(CSUB_LATENCY - 1);
      n_tests++;
      if (out_valid !== 1'b1 || int'(sr) !== e_r || int'(si) !== e_i) begin
         n_fail++;
         $display("FAIL %s got ov=%b sr=%0d si=%0d expected ov=1 sr=%0d si=%0d", name, out_valid, sr, si, e_r, e_i);
      end
      cyc(3);
   endtask

   task automatic test_stall();
      int acc = 0;
      int nexp = 0;
      logic signed [16:0] hold_sr;
      out_ready = 1'b0;
      for (int k = 0; k < 8; k++) begin
         in_valid = (acc < 5);
         in_tag = 4'(acc);
         ar = 16'($urandom); ai = 16'($urandom); br = 16'($urandom); bi = 16'($urandom);
         in_last = (acc == 4);
         @(negedge clk);
         if (k == 4) hold_sr = sr;
         if (in_valid && in_ready) acc++;
         @(posedge clk);
         #1;
      end
      @(negedge clk);
      n_tests++;
      if (acc != 2 || in_ready !== 1'b0) begin
         n_fail++; $display("FAIL stall_buffer got accepted=%0d in_ready=%b expected 2 0", acc, in_ready);
      end
      n_tests++;
      if (sr !== hold_sr || out_valid !== 1'b1) begin
         n_fail++; $display("FAIL stall_stable got sr=%0d ov=%b expected sr=%0d ov=1", sr, out_valid, hold_sr);
      end
      @(posedge clk);
      #1 out_ready = 1'b1;
      for (int k = 0; k < 60 && nexp < 5; k++) begin
         in_valid = (acc < 5);
         in_tag = 4'(acc);
         in_last = (acc == 4);
         ar = 16'($urandom); ai = 16'($urandom); br = 16'($urandom); bi = 16'($urandom);
         @(negedge clk);
         if (out_valid && out_ready) begin
            n_tests++;
            if (int'(out_tag) !== nexp) begin
               n_fail++; $display("FAIL stall_order got tag=%0d expected %0d", out_tag, nexp);
            end
            nexp++;
         end
         if (in_valid && in_ready) acc++;
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
      in_last = 1'b0;
      n_tests++;
      if (nexp != 5) begin
         n_fail++; $display("FAIL stall_drain got %0d beats expected 5", nexp);
      end
      cyc(2);
   endtask

   task automatic test_ce_gating();
      logic [15:0] f_cnt;
      logic f_ov;
      logic signed [16:0] f_sr;
      out_ready = 1'b1;
      for (int k = 0; k < 30; k++) begin
         in_valid = ($urandom_range(0, 3) != 0);
         ar = 16'($urandom); ai = 16'($urandom); br = 16'($urandom); bi = 16'($urandom);
         in_tag = 4'(k);
         if (k == 10) begin
            ce = 1'b0;
            f_cnt = beat_cnt; f_ov = out_valid; f_sr = sr;
         end
         if (k == 13) ce = 1'b1;
         @(negedge clk);
         if (k >= 10 && k < 13) begin
            n_tests++;
            if (beat_cnt !== f_cnt || out_valid !== f_ov || sr !== f_sr || in_ready !== 1'b0) begin
               n_fail++;
               $display("FAIL ce_freeze got cnt=%0d ov=%b sr=%0d rdy=%b expected cnt=%0d ov=%b sr=%0d rdy=0",
                        beat_cnt, out_valid, sr, in_ready, f_cnt, f_ov, f_sr);
            end
         end
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
      cyc(4);
      n_tests++;
      if (q.size() != 0 || out_valid !== 1'b0) begin
         n_fail++; $display("FAIL ce_no_loss got pending=%0d ov=%b expected 0 0", q.size(), out_valid);
      end
   endtask

   task automatic test_last_counter();
      int sent = 0;
      int pulses = 0;
      int hs_k = -1;
      int vd_k = -1;
      pulse_reset();
      out_ready = 1'b1;
      for (int k = 0; k < 14; k++) begin
         in_valid = (sent < 4);
         in_tag = 4'(sent);
         in_last = (sent == 3);
         ar = 16'($urandom); ai = 16'($urandom); br = 16'($urandom); bi = 16'($urandom);
         @(negedge clk);
         if (vec_done) begin
            pulses++; vd_k = k;
         end
         if (out_valid && out_ready && out_last) hs_k = k;
         if (in_valid && in_ready) sent++;
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
      in_last = 1'b0;
      n_tests++;
      if (pulses != 1 || vd_k != hs_k + 1 || hs_k < 0) begin
         n_fail++;
         $display("FAIL vec_done got pulses=%0d at %0d last_hs=%0d expected 1 pulse one cycle after", pulses, vd_k, hs_k);
      end
      n_tests++;
      if (beat_cnt !== 16'd4 || beat_cnt2 !== 2'd0) begin
         n_fail++; $display("FAIL beat_cnt_wrap got %0d/%0d expected 4/0", beat_cnt, beat_cnt2);
      end
   endtask

   task automatic test_random();
      for (int k = 0; k < 3000; k++) begin
         in_valid  = ($urandom_range(0, 9) < 7);
         out_ready = ($urandom_range(0, 9) < 6);
         ce        = ($urandom_range(0, 9) != 0);
         ar = 16'($urandom); ai = 16'($urandom); br = 16'($urandom); bi = 16'($urandom);
         in_tag  = 4'($urandom);
         in_last = ($urandom_range(0, 4) == 0);
         rst = 1'b1;
         @(negedge clk);
         @(posedge clk);
         #1;
         if (k == 1500) #1 rst = 1'b0;
      end
      rst = 1'b1;
      ce = 1'b1;
      out_ready = 1'b1;
      in_valid = 1'b0;
      cyc(5);
      n_tests++;
      if (q.size() != 0 || out_valid !== 1'b0) begin
         n_fail++; $display("FAIL random_drain got pending=%0d ov=%b expected 0 0", q.size(), out_valid);
      end
   endtask

   initial begin
      test_reset();
      test_directed(16'sd100, -16'sd50, 16'sd30, 16'sd20, 70, -70, "basic");
      test_directed(-16'sd32768, 16'sd32767, 16'sd32767, -16'sd32768, -65535, 65535, "extremes");
      test_stall();
      test_ce_gating();
      test_last_counter();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1);
   end

endmodule
